// File: rtl/page_table_walker.sv
// Hardware page-table walker: one PTE fetch per level, leaf permission checks,
// bare/M-mode bypass, flush with in-flight response drain. A/D are never written.
module page_table_walker #(
    parameter int LEVELS    = 3,
    parameter int VPN_WIDTH = 9,
    parameter int PPN_WIDTH = 44,
    parameter int PTE_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [63:0]            req_vaddr,
    input  logic [1:0]             req_type,
    input  logic [1:0]             priv,
    input  logic                   sum,
    input  logic                   mxr,
    input  logic [PPN_WIDTH-1:0]   satp_ppn,
    input  logic                   translator_enable,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [PPN_WIDTH+11:0]  mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [8*PTE_BYTES-1:0] mem_resp_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [PPN_WIDTH+11:0]  resp_paddr,
    output logic                   resp_fault,
    output logic [3:0]             resp_cause
);
    localparam int PA_W    = PPN_WIDTH + 12;
    localparam int VA_BITS = LEVELS * VPN_WIDTH + 12;
    localparam int LVL_W   = $clog2(LEVELS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MEM_REQ  = 3'd1;
    localparam logic [2:0] S_MEM_WAIT = 3'd2;
    localparam logic [2:0] S_RESP     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [63:0]          vaddr_q, vaddr_d;
    logic [1:0]           type_q, type_d;
    logic [1:0]           priv_q, priv_d;
    logic                 sum_q, sum_d, mxr_q, mxr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [PPN_WIDTH-1:0] tbl_ppn_q, tbl_ppn_d;
    logic [PA_W-1:0]      paddr_q, paddr_d;
    logic                 fault_q, fault_d;

    logic [VPN_WIDTH-1:0] vpn;
    logic [PA_W-1:0]      pte_addr, leaf_pa;
    logic [PPN_WIDTH-1:0] pte_ppn, sp_mask, va_ppn;
    logic                 pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic                 is_fetch, is_load, is_store, leaf_fault, bypass, canonical;
    logic [64-VA_BITS:0]  va_hi;

    assign vpn      = VPN_WIDTH'(vaddr_q >> (12 + int'(level_q) * VPN_WIDTH));
    assign pte_addr = {tbl_ppn_q, 12'b0} + PA_W'(vpn) * PA_W'(PTE_BYTES);

    assign pte_v   = mem_resp_data[0];
    assign pte_r   = mem_resp_data[1];
    assign pte_w   = mem_resp_data[2];
    assign pte_x   = mem_resp_data[3];
    assign pte_u   = mem_resp_data[4];
    assign pte_a   = mem_resp_data[6];
    assign pte_d   = mem_resp_data[7];
    assign pte_ppn = mem_resp_data[10 +: PPN_WIDTH];

    // Superpage leaves take their low PPN bits from the VPN fields below the leaf level.
    assign sp_mask = (PPN_WIDTH'(1) << (int'(level_q) * VPN_WIDTH)) - PPN_WIDTH'(1);
    assign va_ppn  = vaddr_q[12 +: PPN_WIDTH];
    assign leaf_pa = {(pte_ppn & ~sp_mask) | (va_ppn & sp_mask), vaddr_q[11:0]};

    assign is_fetch = (type_q == 2'd0);
    assign is_load  = (type_q == 2'd1);
    assign is_store = (type_q == 2'd2);

    assign leaf_fault = (is_fetch & ~pte_x)
                      | (is_load & ~(pte_r | (mxr_q & pte_x)))
                      | (is_store & ~pte_w)
                      | ((priv_q == 2'd0) & ~pte_u)
                      | ((priv_q == 2'd1) & pte_u & (is_fetch | ~sum_q))
                      | ~pte_a
                      | (is_store & ~pte_d)
                      | (|(pte_ppn & sp_mask));

    assign bypass    = ~translator_enable | (priv == 2'd3);
    assign va_hi     = req_vaddr[63:VA_BITS-1];
    assign canonical = (&va_hi) | ~(|va_hi);

    always_comb begin
        state_d   = state_q;
        vaddr_d   = vaddr_q;
        type_d    = type_q;
        priv_d    = priv_q;
        sum_d     = sum_q;
        mxr_d     = mxr_q;
        level_d   = level_q;
        tbl_ppn_d = tbl_ppn_q;
        paddr_d   = paddr_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && req_valid) begin
                    vaddr_d   = req_vaddr;
                    type_d    = req_type;
                    priv_d    = priv;
                    sum_d     = sum;
                    mxr_d     = mxr;
                    level_d   = LVL_W'(LEVELS - 1);
                    tbl_ppn_d = satp_ppn;
                    if (bypass) begin
                        paddr_d = req_vaddr[PA_W-1:0];
                        fault_d = 1'b0;
                        state_d = S_RESP;
                    end else if (!canonical) begin
                        paddr_d = '0;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_MEM_REQ;
                    end
                end
            end
            S_MEM_REQ: begin
                if (flush)              state_d = S_IDLE;
                else if (mem_req_ready) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                // A response landing with the flush has nothing left in flight.
                if (flush) begin
                    state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid) begin
                    state_d = S_RESP;
                    if (!pte_v || (!pte_r && pte_w)) begin
                        paddr_d = '0;
                        fault_d = 1'b1;
                    end else if (!pte_r && !pte_x) begin
                        if (level_q == '0) begin
                            paddr_d = '0;
                            fault_d = 1'b1;
                        end else begin
                            level_d   = level_q - LVL_W'(1);
                            tbl_ppn_d = pte_ppn;
                            state_d   = S_MEM_REQ;
                        end
                    end else begin
                        fault_d = leaf_fault;
                        paddr_d = leaf_fault ? '0 : leaf_pa;
                    end
                end
            end
            S_RESP: begin
                if (flush || resp_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vaddr_q   <= '0;
            type_q    <= '0;
            priv_q    <= '0;
            sum_q     <= 1'b0;
            mxr_q     <= 1'b0;
            level_q   <= '0;
            tbl_ppn_q <= '0;
            paddr_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vaddr_q   <= vaddr_d;
            type_q    <= type_d;
            priv_q    <= priv_d;
            sum_q     <= sum_d;
            mxr_q     <= mxr_d;
            level_q   <= level_d;
            tbl_ppn_q <= tbl_ppn_d;
            paddr_q   <= paddr_d;
            fault_q   <= fault_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign mem_req_addr  = mem_req_valid ? pte_addr : '0;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_paddr    = paddr_q;
    assign resp_fault    = fault_q;

    always_comb begin
        resp_cause = 4'd0;
        if (fault_q) begin
            case (type_q)
                2'd0:    resp_cause = 4'd12;
                2'd1:    resp_cause = 4'd13;
                default: resp_cause = 4'd15;
            endcase
        end
    end

    // G bit, RSW bits and the upper PTE/vaddr bits carry nothing the walker needs.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_resp_data, vaddr_q, req_vaddr};
endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: Sv39 default instance plus a LEVELS=4
// instance, PTEs served from a fixed table.
module tb_page_table_walker;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4;
    logic        req_valid, req_valid4, req_ready, req_ready4;
    logic [63:0] req_vaddr;
    logic [1:0]  req_type, priv;
    logic        sum, mxr, translator_enable, flush;
    logic [43:0] satp_ppn;
    logic        mem_req_valid, mem_req_valid4, mem_req_ready, mem_req_ready4;
    logic [55:0] mem_req_addr, mem_req_addr4;
    logic        mem_resp_valid, mem_resp_valid4;
    logic [63:0] mem_resp_data;
    logic        resp_valid, resp_valid4, resp_ready;
    logic [55:0] resp_paddr, resp_paddr4;
    logic        resp_fault, resp_fault4;
    logic [3:0]  resp_cause, resp_cause4;

    int vectors = 0;
    int miscompares = 0;

    page_table_walker dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_type(req_type), .priv(priv), .sum(sum), .mxr(mxr),
        .satp_ppn(satp_ppn), .translator_enable(translator_enable), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_fault(resp_fault), .resp_cause(resp_cause)
    );

    page_table_walker #(.LEVELS(4)) dut4 (
        .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_vaddr(req_vaddr), .req_type(req_type), .priv(priv), .sum(sum), .mxr(mxr),
        .satp_ppn(satp_ppn), .translator_enable(translator_enable), .flush(flush),
        .mem_req_valid(mem_req_valid4), .mem_req_ready(mem_req_ready4), .mem_req_addr(mem_req_addr4),
        .mem_resp_valid(mem_resp_valid4), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_paddr(resp_paddr4),
        .resp_fault(resp_fault4), .resp_cause(resp_cause4)
    );

    function automatic logic [63:0] mk(input logic [43:0] ppn, input logic [7:0] fl);
        return {10'd0, ppn, 2'b00, fl};
    endfunction

    // Flags: 01=pointer, C7=v r w a d, 47=v r w a, 5B=v r x u a, 49=v x a.
    function automatic logic [63:0] pte(input logic [55:0] a);
        case (a)
            56'h8000_0000: return mk(44'h80001, 8'h01);
            56'h8000_1400: return mk(44'h80002, 8'h01);
            56'h8000_1408: return mk(44'h80200, 8'hC7);
            56'h8000_1410: return mk(44'h80201, 8'hC7);
            56'h8000_2000: return mk(44'h80123, 8'hC7);
            56'h8000_2008: return mk(44'h80124, 8'hC7);
            56'h8000_2010: return mk(44'h80125, 8'h47);
            56'h8000_2018: return mk(44'h80126, 8'h5B);
            56'h8000_2020: return mk(44'h80127, 8'h49);
            56'h8000_2030: return mk(44'h80003, 8'h01);
            56'h8000_1000: return mk(44'h80004, 8'h01);
            56'h8000_4400: return mk(44'h80005, 8'h01);
            56'h8000_5000: return mk(44'h80123, 8'hC7);
            default:       return 64'd0;
        endcase
    endfunction

    // Issue one request to the Sv39 instance, serve every PTE fetch after one
    // stall cycle, then hold the response one cycle before taking it.
    task automatic run_req(input logic [63:0] va, input logic [1:0] typ, input logic [1:0] pv,
                           input logic s, input logic m, input logic en,
                           output logic got, output int nmem, output int idle,
                           output logic [55:0] fa, output logic [55:0] pa, output logic flt,
                           output logic [3:0] cause, output logic vld_held,
                           output logic [55:0] pa_held, output logic vld_after);
        logic [55:0] a;
        got = 0; nmem = 0; idle = 0; fa = '0; pa = '0; flt = 0; cause = '0;
        vld_held = 0; pa_held = '0; vld_after = 0;
        @(negedge clk);
        req_vaddr = va; req_type = typ; priv = pv; sum = s; mxr = m;
        translator_enable = en; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        for (int cyc = 0; cyc < 60 && !got; cyc++) begin
            if (resp_valid) begin
                got = 1; pa = resp_paddr; flt = resp_fault; cause = resp_cause;
            end else if (mem_req_valid) begin
                a = mem_req_addr;
                if (nmem == 0) fa = a;
                nmem++;
                @(negedge clk);
                if (!mem_req_valid) idle++;
                mem_req_ready = 1;
                @(negedge clk);
                mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = pte(a);
                @(negedge clk);
                mem_resp_valid = 0;
            end else begin
                idle++;
                @(negedge clk);
            end
        end
        if (got) begin
            @(negedge clk);
            vld_held = resp_valid; pa_held = resp_paddr;
            resp_ready = 1;
            @(negedge clk);
            resp_ready = 0; vld_after = resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1; rst4 = 1;
        repeat (3) @(negedge clk);
        rst = 0; rst4 = 0;
        vectors++;
        if ({req_ready, mem_req_valid, resp_valid, resp_fault, resp_cause} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 10000000", {req_ready, mem_req_valid, resp_valid, resp_fault, resp_cause});
        end
        vectors++;
        if ({resp_paddr, mem_req_addr} !== 112'd0) begin
            miscompares++;
            $display("FAIL reset_addr paddr %h mem_addr %h want 0", resp_paddr, mem_req_addr);
        end
    endtask

    task automatic test_bypass();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        logic [63:0] vas [3] = '{64'h8000_1234, 64'h8000_1234, 64'hFFFF_0000_8000_1234};
        logic [1:0]  pvs [3] = '{2'd1, 2'd3, 2'd1};
        logic        ens [3] = '{1'b0, 1'b1, 1'b0};
        logic [55:0] exp [3] = '{56'h8000_1234, 56'h8000_1234, 56'hFF_0000_8000_1234};
        for (int i = 0; i < 3; i++) begin
            run_req(vas[i], 2'd1, pvs[i], 1'b0, 1'b0, ens[i], got, n, idle, fa, pa, f, c, vh, pah, va);
            vectors++;
            if (!got || idle != 0 || n != 0) begin
                miscompares++;
                $display("FAIL bypass_timing[%0d] got=%0d idle=%0d mem=%0d want 1/0/0", i, got, idle, n);
            end
            vectors++;
            if ({pa, f, c} !== {exp[i], 1'b0, 4'd0}) begin
                miscompares++;
                $display("FAIL bypass_result[%0d] pa %h f %b c %0d want %h 0 0", i, pa, f, c, exp[i]);
            end
        end
    endtask

    task automatic test_walk();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        run_req(64'h1000_0ABC, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
        vectors++;
        if (!got || n != 3 || idle != 0) begin
            miscompares++;
            $display("FAIL walk_handshakes got=%0d mem=%0d idle=%0d want 1/3/0", got, n, idle);
        end
        vectors++;
        if (fa !== 56'h8000_0000) begin
            miscompares++; $display("FAIL walk_first_addr got %h want 80000000", fa);
        end
        vectors++;
        if ({pa, f, c} !== {56'h8012_3ABC, 1'b0, 4'd0}) begin
            miscompares++; $display("FAIL walk_paddr got %h f %b c %0d want 80123abc 0 0", pa, f, c);
        end
        vectors++;
        if ({vh, pah, va} !== {1'b1, 56'h8012_3ABC, 1'b0}) begin
            miscompares++; $display("FAIL walk_hold vld %b pa %h after %b want 1 80123abc 0", vh, pah, va);
        end
    endtask

    task automatic test_perm_faults();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        logic [63:0] vas [11] = '{64'h1000_1ABC, 64'h1000_2ABC, 64'h1000_2ABC, 64'h1000_3ABC,
                                  64'h1000_3ABC, 64'h1000_3ABC, 64'h1000_3ABC, 64'h1000_4ABC,
                                  64'h1000_4ABC, 64'h1000_5ABC, 64'h1000_6ABC};
        logic [1:0]  tys [11] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        logic [1:0]  pvs [11] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        logic        sms [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic        mxs [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [60:0] exp [11] = '{{56'd0, 1'b1, 4'd13}, {56'd0, 1'b1, 4'd15},
                                  {56'h8012_5ABC, 1'b0, 4'd0}, {56'd0, 1'b1, 4'd12},
                                  {56'h8012_6ABC, 1'b0, 4'd0}, {56'h8012_6ABC, 1'b0, 4'd0},
                                  {56'd0, 1'b1, 4'd13}, {56'd0, 1'b1, 4'd13},
                                  {56'h8012_7ABC, 1'b0, 4'd0}, {56'd0, 1'b1, 4'd13},
                                  {56'd0, 1'b1, 4'd13}};
        for (int i = 0; i < 11; i++) begin
            run_req(vas[i], tys[i], pvs[i], sms[i], mxs[i], 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
            vectors++;
            if (!got || n != 3 || {pa, f, c} !== exp[i]) begin
                miscompares++;
                $display("FAIL perm[%0d] got=%0d mem=%0d pa %h f %b c %0d want mem 3 %h", i, got, n, pa, f, c, exp[i]);
            end
        end
    endtask

    task automatic test_superpage();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        run_req(64'h103A_5123, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
        vectors++;
        if (!got || n != 2 || {pa, f, c} !== {56'h803A_5123, 1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL superpage_ok got=%0d mem=%0d pa %h f %b c %0d want 2 803a5123 0 0", got, n, pa, f, c);
        end
        run_req(64'h105A_5123, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
        vectors++;
        if (!got || n != 2 || {pa, f, c} !== {56'd0, 1'b1, 4'd13}) begin
            miscompares++;
            $display("FAIL superpage_misaligned got=%0d mem=%0d pa %h f %b c %0d want 2 0 1 13", got, n, pa, f, c);
        end
    endtask

    task automatic test_canonical();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        run_req(64'h0000_0040_0000_0000, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
        vectors++;
        if (!got || n != 0 || idle != 0 || {f, c} !== {1'b1, 4'd13}) begin
            miscompares++;
            $display("FAIL noncanonical got=%0d mem=%0d idle=%0d f %b c %0d want 1 0 0 1 13", got, n, idle, f, c);
        end
    endtask

    task automatic test_flush();
        logic got, f, vh, va; int n, idle; logic [55:0] fa, pa, pah; logic [3:0] c;
        translator_enable = 1; priv = 2'd1; req_type = 2'd2; req_vaddr = 64'h1000_0ABC;
        @(negedge clk);
        req_valid = 1; flush = 1;
        @(negedge clk);
        req_valid = 0; flush = 0;
        vectors++;
        if ({req_ready, mem_req_valid, resp_valid} !== 3'b100) begin
            miscompares++; $display("FAIL flush_vs_req got %b want 100", {req_ready, mem_req_valid, resp_valid});
        end
        req_valid = 1;
        @(negedge clk);
        req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        vectors++;
        if ({req_ready, mem_req_valid, resp_valid} !== 3'b000) begin
            miscompares++; $display("FAIL flush_drain got %b want 000", {req_ready, mem_req_valid, resp_valid});
        end
        mem_resp_valid = 1; mem_resp_data = pte(56'h8000_0000);
        @(negedge clk);
        mem_resp_valid = 0;
        @(negedge clk);
        vectors++;
        if ({req_ready, mem_req_valid, resp_valid} !== 3'b100) begin
            miscompares++; $display("FAIL flush_drain_done got %b want 100", {req_ready, mem_req_valid, resp_valid});
        end
        req_valid = 1;
        @(negedge clk);
        req_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        vectors++;
        if ({req_ready, mem_req_valid, resp_valid} !== 3'b100) begin
            miscompares++; $display("FAIL flush_mem_req got %b want 100", {req_ready, mem_req_valid, resp_valid});
        end
        translator_enable = 0; req_valid = 1;
        @(negedge clk);
        req_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        vectors++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL flush_resp got %b want 10", {req_ready, resp_valid});
        end
        run_req(64'h1000_0ABC, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, got, n, idle, fa, pa, f, c, vh, pah, va);
        vectors++;
        if (!got || n != 3 || {pa, f} !== {56'h8012_3ABC, 1'b0}) begin
            miscompares++; $display("FAIL flush_next_walk got=%0d mem=%0d pa %h f %b want 3 80123abc 0", got, n, pa, f);
        end
    endtask

    task automatic test_levels4();
        logic got; int n; logic [55:0] fa, a; logic [63:0] d;
        got = 0; n = 0; fa = '0;
        @(negedge clk);
        req_vaddr = 64'h1000_0ABC; req_type = 2'd2; priv = 2'd1; sum = 0; mxr = 0;
        translator_enable = 1; req_valid4 = 1;
        @(negedge clk);
        req_valid4 = 0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            if (resp_valid4) begin
                got = 1;
                vectors++;
                if ({resp_paddr4, resp_fault4} !== {56'h8012_3ABC, 1'b0}) begin
                    miscompares++; $display("FAIL l4_paddr got %h f %b want 80123abc 0", resp_paddr4, resp_fault4);
                end
            end else if (mem_req_valid4) begin
                a = mem_req_addr4;
                if (n == 0) fa = a;
                n++; d = pte(a);
                @(negedge clk);
                mem_resp_valid4 = 1; mem_resp_data = d;
                @(negedge clk);
                mem_resp_valid4 = 0;
            end else begin
                @(negedge clk);
            end
        end
        vectors++;
        if (!got || n != 4 || fa !== 56'h8000_0000) begin
            miscompares++; $display("FAIL l4_walk got=%0d mem=%0d first %h want 1 4 80000000", got, n, fa);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        req_valid4 = 1;
        @(negedge clk);
        req_valid4 = 0;
        @(negedge clk);
        mem_resp_valid4 = 1; mem_resp_data = pte(56'h8000_0000);
        @(negedge clk);
        mem_resp_valid4 = 0;
        vectors++;
        if ({mem_req_valid4, mem_req_addr4} !== {1'b1, 56'h8000_1000}) begin
            miscompares++; $display("FAIL l4_level2_addr got %b %h want 1 80001000", mem_req_valid4, mem_req_addr4);
        end
        @(negedge clk);
        rst4 = 1;
        @(negedge clk);
        rst4 = 0;
        vectors++;
        if ({req_ready4, mem_req_valid4, resp_valid4, resp_fault4, resp_cause4, resp_paddr4, mem_req_addr4} !== {4'b1000, 4'd0, 112'd0}) begin
            miscompares++;
            $display("FAIL l4_reset_mid_walk rdy %b mv %b rv %b f %b c %0d pa %h ma %h want idle zeros",
                     req_ready4, mem_req_valid4, resp_valid4, resp_fault4, resp_cause4, resp_paddr4, mem_req_addr4);
        end
        mem_resp_valid4 = 1; mem_resp_data = pte(56'h8000_1000);
        @(negedge clk);
        mem_resp_valid4 = 0;
        @(negedge clk);
        vectors++;
        if ({req_ready4, mem_req_valid4, resp_valid4} !== 3'b100) begin
            miscompares++; $display("FAIL l4_stale_resp got %b want 100", {req_ready4, mem_req_valid4, resp_valid4});
        end
    endtask

    initial begin
        rst = 1; rst4 = 1; req_valid = 0; req_valid4 = 0; req_vaddr = '0; req_type = '0;
        priv = '0; sum = 0; mxr = 0; satp_ppn = 44'h80000; translator_enable = 1; flush = 0;
        mem_req_ready = 0; mem_req_ready4 = 1; mem_resp_valid = 0; mem_resp_valid4 = 0;
        mem_resp_data = '0; resp_ready = 0;
        test_reset();
        test_bypass();
        test_walk();
        test_perm_faults();
        test_superpage();
        test_canonical();
        test_flush();
        test_levels4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
